// File: rtl/vn_mem_arbiter.sv
// Shares one ByteRAM between instruction fetch and load/store.
// Round-robin arbitration, fault checks, registered responses.
module vn_mem_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'd1024,
  parameter logic [31:0] STOP_ADDRESS  = START_ADDRESS + 32'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_len,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] wr_addr,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [1:0]  by_wlen,
  output logic [31:0] rd_addr,
  output logic        rd_en,
  output logic [1:0]  by_rlen,
  input  logic [31:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_last_d;
  logic r_own_d;
  logic r_fault;
  logic r_is_read;

  logic        w_req_any;
  logic        w_sel_d;
  logic [31:0] w_addr;
  logic [1:0]  w_len;
  logic        w_we;
  logic [32:0] w_end;
  logic        w_fault;

  assign w_req_any = if_req | d_req;

  // 33-bit end address so requests near 0xFFFFFFFF cannot wrap into range
  always_comb begin
    w_sel_d = d_req & (~if_req | ~r_last_d);
    w_addr  = w_sel_d ? d_addr : if_addr;
    w_len   = w_sel_d ? d_len : 2'd3;
    w_we    = w_sel_d & d_we;
    w_end   = {1'b0, w_addr} + {31'd0, w_len};
    w_fault = (w_len == 2'd2)
            | ((w_len == 2'd1) & w_addr[0])
            | ((w_len == 2'd3) & (w_addr[1:0] != 2'd0))
            | (w_addr < START_ADDRESS)
            | (w_end > {1'b0, STOP_ADDRESS});
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_req_any) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = (r_is_read && !r_fault) ? S_RESP : S_IDLE;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d  <= 1'b0;
      r_own_d   <= 1'b0;
      r_fault   <= 1'b0;
      r_is_read <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      if_err    <= 1'b0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
      wr_addr   <= 32'd0;
      wr_en     <= 1'b0;
      wr_data   <= 32'd0;
      by_wlen   <= 2'd0;
      rd_addr   <= 32'd0;
      rd_en     <= 1'b0;
      by_rlen   <= 2'd0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_last_d  <= w_sel_d;
            r_own_d   <= w_sel_d;
            r_fault   <= w_fault;
            r_is_read <= ~w_we;
            if_gnt    <= ~w_sel_d;
            d_gnt     <= w_sel_d;
            if (!w_fault && w_we) begin
              wr_en   <= 1'b1;
              wr_addr <= w_addr;
              wr_data <= d_wdata;
              by_wlen <= w_len;
            end else if (!w_fault) begin
              rd_en   <= 1'b1;
              rd_addr <= w_addr;
              by_rlen <= w_len;
            end
          end
        end
        S_ACCESS: begin
          if (r_fault) begin
            if_err <= ~r_own_d;
            d_err  <= r_own_d;
          end
        end
        S_RESP: begin
          if (r_own_d) begin
            d_rdata  <= rd_data;
            d_rvalid <= 1'b1;
          end else begin
            if_rdata  <= rd_data;
            if_rvalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
